sync_fifo_flags: RTL
====================

Name: sync_fifo_flags

Overview:
- Parametrised circular-buffer FIFO. Successor to the shift-register data buffer used between SPI shift logic and the host side.
- Adds independent read/write pointers, an occupancy count, and full/empty and almost-full/almost-empty status.
- Adds sticky overflow/underflow flags, a synchronous flush and a flag clear.
- Output is first-word fall-through: the head word is presented on data_out without a read strobe.

Parameters:
- WORD_SIZE, 8, data width in bits (>=1).
- DEPTH, 4, number of entries; power of two, >=2.
- ALMOST_FULL_LEVEL, DEPTH-1, almost_full asserts when count >= this value (1..DEPTH).
- ALMOST_EMPTY_LEVEL, 1, almost_empty asserts when count <= this value (0..DEPTH-1).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous empty; discards contents.
- clear_flags  in  1  synchronous clear of the sticky overflow/underflow flags.
- write  in  1  push data_in this cycle.
- read  in  1  pop the head word this cycle.
- data_in  in  WORD_SIZE  write data.
- data_out  out  WORD_SIZE  head word (FWFT); 0 when empty.
- count  out  $clog2(DEPTH)+1  occupancy, 0..DEPTH.
- buffer_full  out  1  count == DEPTH.
- buffer_empty  out  1  count == 0.
- almost_full  out  1  count >= ALMOST_FULL_LEVEL.
- almost_empty  out  1  count <= ALMOST_EMPTY_LEVEL.
- overflow  out  1  sticky: a write was attempted while full.
- underflow  out  1  sticky: a read was attempted while empty.

Behaviour:
- Clocking and reset:
  - Single clock domain, clk.
  - rst is asynchronous and active-high. While asserted: pointers = 0, count = 0, overflow = underflow = 0.
  - Reset outputs: buffer_empty = 1, almost_empty = 1, buffer_full = 0, almost_full = 0 (unless ALMOST_FULL_LEVEL == 0, which is disallowed), data_out = 0.
  - Storage array is not reset.
  - Reset mid-operation discards all contents immediately.
- Storage and pointers:
  - DEPTH x WORD_SIZE array, write pointer wr_ptr, read pointer rd_ptr.
  - Both pointers are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
  - count is held in a separate register, not derived from the pointers.
- Status outputs:
  - All status outputs are combinational from count.
  - data_out = buffer_empty ? 0 : mem[rd_ptr].
- Accept rules, evaluated at the rising edge using pre-edge state:
  - wr_ok = write & (~buffer_full | read).
  - rd_ok = read & ~buffer_empty.
  - wr_ok: mem[wr_ptr] <= data_in; wr_ptr++.
  - rd_ok: rd_ptr++.
  - count update: +1 when only wr_ok, -1 when only rd_ok, unchanged when both or neither.
- Simultaneous events:
  - Read and write while full: both are accepted; count stays DEPTH; no overflow.
  - Read and write while empty: the write is accepted and the read is rejected; count becomes 1; underflow sets.
  - A written word is visible on data_out in the cycle after its write edge (one-cycle write-to-read latency).
- Error flags:
  - Write while full without a read: data dropped, state unchanged, overflow <= 1.
  - Read while empty: no state change, underflow <= 1.
  - Both flags hold until rst, flush or clear_flags.
  - If clear_flags coincides with a new error event, set wins.
- flush:
  - Takes priority over read and write in the same cycle.
  - Next edge: pointers = 0, count = 0, both flags = 0.
  - Write data presented in the flush cycle is discarded.
- Parameter checks:
  - Elaboration error if DEPTH is not a power of two or < 2.
  - Elaboration error if either threshold is outside its allowed range.

Test Plan:
1. Reset, then write 0xA1,0xB2,0xC3,0xD4 (DEPTH=4) -> count 1..4; buffer_full=1 after the 4th write; almost_full=1 from count 3; data_out=0xA1 throughout.
2. From full, write 0xEE alone -> overflow=1, count=4, contents unchanged. Then read 4 times -> data_out sequence 0xA1,0xB2,0xC3,0xD4, then 0 with buffer_empty=1.
3. Read while empty -> underflow=1, count=0. Pulse clear_flags -> underflow=0. Pulse clear_flags together with another empty read -> underflow stays 1.
4. Full FIFO, assert read+write(0x55) for one cycle -> count stays 4, no overflow, new head 0xB2, 0x55 is read out last. Repeat 10 cycles to exercise pointer wrap -> output order matches input order.
5. Empty FIFO, read+write(0x77) same cycle -> count=1, underflow=1, data_out=0x77 next cycle.
6. Count at 3, assert flush+write(0x99) -> count=0, buffer_empty=1, flags cleared, 0x99 not stored. Assert rst asynchronously mid-burst -> outputs reach reset values without a clock edge.

Source files
------------

// File: rtl/sync_fifo_flags.sv
// First-word fall-through circular FIFO with a separate occupancy count,
// full/empty and almost-full/almost-empty status, and sticky error flags.
module sync_fifo_flags #(
  parameter int WORD_SIZE          = 8,
  parameter int DEPTH              = 4,
  parameter int ALMOST_FULL_LEVEL  = DEPTH - 1,
  parameter int ALMOST_EMPTY_LEVEL = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       clear_flags,
  input  logic                       write,
  input  logic                       read,
  input  logic [WORD_SIZE-1:0]       data_in,
  output logic [WORD_SIZE-1:0]       data_out,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       buffer_full,
  output logic                       buffer_empty,
  output logic                       almost_full,
  output logic                       almost_empty,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("sync_fifo_flags: DEPTH must be a power of two >= 2");
  end

  if (ALMOST_FULL_LEVEL < 1 || ALMOST_FULL_LEVEL > DEPTH) begin : g_bad_af
    $error("sync_fifo_flags: ALMOST_FULL_LEVEL out of range");
  end

  if (ALMOST_EMPTY_LEVEL < 0 ||
      ALMOST_EMPTY_LEVEL > DEPTH - 1) begin : g_bad_ae
    $error("sync_fifo_flags: ALMOST_EMPTY_LEVEL out of range");
  end

  logic [WORD_SIZE-1:0] mem [DEPTH];
  logic [PTR_W-1:0]     wr_ptr;
  logic [PTR_W-1:0]     rd_ptr;

  logic wr_ok;
  logic rd_ok;
  logic ovf_set;
  logic unf_set;

  assign buffer_full  = (count == CNT_W'(DEPTH));
  assign buffer_empty = (count == '0);
  assign almost_full  = (count >= CNT_W'(ALMOST_FULL_LEVEL));
  assign almost_empty = (count <= CNT_W'(ALMOST_EMPTY_LEVEL));

  assign data_out = buffer_empty ? '0 : mem[rd_ptr];

  // A read frees a slot in the same edge, so a full FIFO can still take a write.
  assign wr_ok   = write & (~buffer_full | read);
  assign rd_ok   = read & ~buffer_empty;
  assign ovf_set = write & buffer_full & ~read;
  assign unf_set = read & buffer_empty;

  always_ff @(posedge clk) begin
    if (wr_ok && !flush) begin
      mem[wr_ptr] <= data_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (flush) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_ok) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (rd_ok) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      unique case (1'b1)
        wr_ok && !rd_ok: count <= count + CNT_W'(1);
        rd_ok && !wr_ok: count <= count - CNT_W'(1);
        default:         count <= count;
      endcase
      // A fresh error event outranks a coincident clear.
      overflow  <= (overflow  & ~clear_flags) | ovf_set;
      underflow <= (underflow & ~clear_flags) | unf_set;
    end
  end

endmodule
